ser_xfer_ctrl: RTL and testbench

//  Sequences one serial transfer over the SB shift register.
//  - Owns the SC register (start bit, clock select).
//  - Generates or tracks the serial clock.
//  - Issues per-bit out/shift strobes to the SB shifter.
//  - Counts bits and raises the serial interrupt when the transfer completes.
//  - Sits between the CPU register bus and the shifter/pin logic.

---
 rtl/ser_xfer_ctrl_if.sv | 30 +++
 rtl/ser_xfer_ctrl.sv | 129 ++++++++++++
 tb/tb_ser_xfer_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ser_xfer_ctrl_if.sv
// Bus bundle between the CPU/pin side and the serial transfer controller.
// The controller takes the slave view; the CPU register bus and pin logic take the master view.
interface ser_xfer_ctrl_if #(
   parameter int NBITS = 8
);
   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

   logic          sc_write;
   logic [7:0]    sc_wdata;
   logic [7:0]    sc_rdata;
   logic          tick_in;
   logic          sck_in;
   logic          sck_out;
   logic          sck_oe;
   logic          out_en;
   logic          shift_en;
   logic          busy;
   logic [CW-1:0] bit_cnt;
   logic          int_serial;

   modport master (
      output sc_write, sc_wdata, tick_in, sck_in,
      input  sc_rdata, sck_out, sck_oe, out_en, shift_en, busy, bit_cnt, int_serial
   );

   modport slave (
      input  sc_write, sc_wdata, tick_in, sck_in,
      output sc_rdata, sck_out, sck_oe, out_en, shift_en, busy, bit_cnt, int_serial
   );
endinterface

// File: rtl/ser_xfer_ctrl.sv
// Serial transfer sequencer: owns the SC register, drives or follows the serial clock,
// and issues per-bit out/shift strobes to the SB shifter plus a completion interrupt.
module ser_xfer_ctrl #(
   parameter int NBITS       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   ser_xfer_ctrl_if.slave bus
);
   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      LOW,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic                   start_q, start_d;
   logic                   clksel_q, clksel_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sck_prev_q;
   logic                   rise_q, fall_q;
   logic                   step;
   logic                   out_en, shift_en, int_serial;
   logic                   unused_wdata;

   // External clock: synchronize, then register a one-cycle edge pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '1;
         sck_prev_q <= 1'b1;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
         sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.sck_in};
         sck_prev_q <= sync_q[SYNC_STAGES-1];
         rise_q     <= sync_q[SYNC_STAGES-1] & ~sck_prev_q;
         fall_q     <= ~sync_q[SYNC_STAGES-1] & sck_prev_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         start_q  <= 1'b0;
         clksel_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         clksel_q <= clksel_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d    = state_q;
      start_d    = start_q;
      clksel_d   = clksel_q;
      cnt_d      = cnt_q;
      out_en     = 1'b0;
      shift_en   = 1'b0;
      int_serial = 1'b0;
      step       = 1'b0;

      // A register write in the same cycle swallows the tick or edge.
      if (!bus.sc_write) begin
         if (clksel_q)
            step = bus.tick_in;
         else if (state_q == ARMED)
            step = fall_q;
         else if (state_q == LOW)
            step = rise_q;
      end

      case (state_q)
         ARMED: begin
            if (step) begin
               out_en  = 1'b1;
               state_d = LOW;
            end
         end
         LOW: begin
            if (step) begin
               shift_en = 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = DONE;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ARMED;
               end
            end
         end
         DONE: begin
            int_serial = 1'b1;
            start_d    = 1'b0;
            cnt_d      = '0;
            state_d    = IDLE;
         end
         default: ;
      endcase

      // Start=1 (re)arms from bit 0; start=0 aborts without an interrupt.
      if (bus.sc_write) begin
         clksel_d = bus.sc_wdata[0];
         start_d  = bus.sc_wdata[7];
         cnt_d    = '0;
         state_d  = bus.sc_wdata[7] ? ARMED : IDLE;
      end
   end

   assign unused_wdata   = ^bus.sc_wdata[6:1];

   assign bus.sc_rdata   = {start_q, 6'b111111, clksel_q};
   assign bus.sck_out    = (state_q != LOW);
   assign bus.sck_oe     = clksel_q;
   assign bus.busy       = start_q;
   assign bus.bit_cnt    = cnt_q;
   assign bus.out_en     = out_en;
   assign bus.shift_en   = shift_en;
   assign bus.int_serial = int_serial;
endmodule

// File: tb/tb_ser_xfer_ctrl.sv
// Directed bench for ser_xfer_ctrl: a vector table for a full internal-clock transfer,
// plus hand-written sequences for reset, external clock, abort, write/tick collision.
module tb_ser_xfer_ctrl;
   logic clk;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   ser_xfer_ctrl_if #(.NBITS(8)) bus ();

   ser_xfer_ctrl #(.NBITS(8), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       wr;
      logic [7:0] wd;
      logic       tick;
      logic       out_en;
      logic       shift_en;
      logic       int_serial;
      logic       busy;
      logic [2:0] cnt;
      logic       sck_out;
      logic       sck_oe;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs [19];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs just after a falling edge; they are taken at the next rising edge.
   task automatic step_cyc(input logic wr, input logic [7:0] wd, input logic tk);
      @(negedge clk);
      bus.sc_write = wr;
      bus.sc_wdata = wd;
      bus.tick_in  = tk;
      #1;
   endtask

   initial begin
      int strobes;

      reset        = 1'b1;
      bus.sc_write = 1'b0;
      bus.sc_wdata = 8'h00;
      bus.tick_in  = 1'b0;
      bus.sck_in   = 1'b1;
      #2;
      check("rst.busy", 32'(bus.busy), 32'd0);
      check("rst.sck_out", 32'(bus.sck_out), 32'd1);
      check("rst.sck_oe", 32'(bus.sck_oe), 32'd0);
      check("rst.bit_cnt", 32'(bus.bit_cnt), 32'd0);
      check("rst.strobes", 32'({bus.out_en, bus.shift_en, bus.int_serial}), 32'd0);
      check("rst.rdata", 32'(bus.sc_rdata), 32'h7E);
      @(negedge clk);
      reset = 1'b0;

      // Full internal-clock transfer, one tick per cycle.
      vecs[0] = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h7E};
      for (int k = 1; k <= 16; k++)
         vecs[k] = '{1'b0, 8'h00, 1'b1, logic'(k % 2), logic'((k + 1) % 2), 1'b0, 1'b1,
                     3'((k - 1) / 2), logic'(k % 2), 1'b1, 8'hFF};
      vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 8'hFF};
      vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 8'h7F};

      for (int i = 0; i < 19; i++) begin
         step_cyc(vecs[i].wr, vecs[i].wd, vecs[i].tick);
         check($sformatf("v%0d.out_en", i), 32'(bus.out_en), 32'(vecs[i].out_en));
         check($sformatf("v%0d.shift_en", i), 32'(bus.shift_en), 32'(vecs[i].shift_en));
         check($sformatf("v%0d.int_serial", i), 32'(bus.int_serial), 32'(vecs[i].int_serial));
         check($sformatf("v%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
         check($sformatf("v%0d.bit_cnt", i), 32'(bus.bit_cnt), 32'(vecs[i].cnt));
         check($sformatf("v%0d.sck_out", i), 32'(bus.sck_out), 32'(vecs[i].sck_out));
         check($sformatf("v%0d.sck_oe", i), 32'(bus.sck_oe), 32'(vecs[i].sck_oe));
         check($sformatf("v%0d.rdata", i), 32'(bus.sc_rdata), 32'(vecs[i].rdata));
      end

      // Asynchronous reset in the middle of a transfer (bit_cnt=3).
      step_cyc(1'b1, 8'h81, 1'b0);
      for (int k = 0; k < 6; k++) step_cyc(1'b0, 8'h00, 1'b1);
      step_cyc(1'b0, 8'h00, 1'b0);
      check("midrst.pre_cnt", 32'(bus.bit_cnt), 32'd3);
      reset = 1'b1;
      #1;
      check("midrst.busy", 32'(bus.busy), 32'd0);
      check("midrst.sck_out", 32'(bus.sck_out), 32'd1);
      check("midrst.sck_oe", 32'(bus.sck_oe), 32'd0);
      check("midrst.bit_cnt", 32'(bus.bit_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // External clock, 8 periods of 10 clk; strobes appear 3 clk after each edge.
      step_cyc(1'b1, 8'h80, 1'b0);
      step_cyc(1'b0, 8'h00, 1'b0);
      for (int p = 0; p < 8; p++) begin
         for (int h = 0; h < 2; h++) begin
            bus.sck_in = logic'(h);
            for (int c = 1; c <= 5; c++) begin
               @(negedge clk);
               #1;
               check($sformatf("ext.p%0d.h%0d.c%0d.out_en", p, h, c), 32'(bus.out_en),
                     32'(h == 0 && c == 3));
               check($sformatf("ext.p%0d.h%0d.c%0d.shift_en", p, h, c), 32'(bus.shift_en),
                     32'(h == 1 && c == 3));
               check($sformatf("ext.p%0d.h%0d.c%0d.int", p, h, c), 32'(bus.int_serial),
                     32'(p == 7 && h == 1 && c == 4));
               check($sformatf("ext.p%0d.h%0d.c%0d.sck_oe", p, h, c), 32'(bus.sck_oe), 32'd0);
            end
         end
      end
      check("ext.end_busy", 32'(bus.busy), 32'd0);
      check("ext.end_cnt", 32'(bus.bit_cnt), 32'd0);

      // Abort after 3 bits of an internal transfer; later ticks do nothing.
      step_cyc(1'b1, 8'h81, 1'b0);
      for (int k = 0; k < 6; k++) step_cyc(1'b0, 8'h00, 1'b1);
      step_cyc(1'b1, 8'h01, 1'b1);
      check("abort.write_cycle_out_en", 32'(bus.out_en), 32'd0);
      strobes = 0;
      for (int k = 0; k < 4; k++) begin
         step_cyc(1'b0, 8'h00, 1'b1);
         strobes += int'(bus.out_en) + int'(bus.shift_en) + int'(bus.int_serial);
      end
      check("abort.strobes", 32'(strobes), 32'd0);
      check("abort.busy", 32'(bus.busy), 32'd0);
      check("abort.sck_out", 32'(bus.sck_out), 32'd1);
      check("abort.bit_cnt", 32'(bus.bit_cnt), 32'd0);
      check("abort.rdata", 32'(bus.sc_rdata), 32'h7F);

      // Restart write collides with a tick while in LOW at bit_cnt=2.
      step_cyc(1'b1, 8'h81, 1'b0);
      for (int k = 0; k < 5; k++) step_cyc(1'b0, 8'h00, 1'b1);
      step_cyc(1'b1, 8'h81, 1'b1);
      check("collide.pre_cnt", 32'(bus.bit_cnt), 32'd2);
      check("collide.pre_sck_out", 32'(bus.sck_out), 32'd0);
      check("collide.shift_en", 32'(bus.shift_en), 32'd0);
      step_cyc(1'b0, 8'h00, 1'b1);
      check("collide.bit_cnt", 32'(bus.bit_cnt), 32'd0);
      check("collide.sck_out", 32'(bus.sck_out), 32'd1);
      check("collide.armed_out_en", 32'(bus.out_en), 32'd1);
      step_cyc(1'b1, 8'h00, 1'b0);

      // External mode with only ticks: nothing moves.
      step_cyc(1'b1, 8'h80, 1'b0);
      strobes = 0;
      for (int k = 0; k < 10; k++) begin
         step_cyc(1'b0, 8'h00, 1'b1);
         strobes += int'(bus.out_en) + int'(bus.shift_en) + int'(bus.int_serial);
      end
      check("extticks.strobes", 32'(strobes), 32'd0);
      check("extticks.busy", 32'(bus.busy), 32'd1);
      check("extticks.rdata", 32'(bus.sc_rdata), 32'hFE);
      check("extticks.sck_out", 32'(bus.sck_out), 32'd1);
      step_cyc(1'b1, 8'h00, 1'b0);
      step_cyc(1'b0, 8'h00, 1'b0);
      check("final.busy", 32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
